// File: rtl/prbs_bist_ctrl_if.sv
// Loopback link between the BIST controller and the PRBS datapath.
// The controller drives tx and consumes the returned rx words.
interface prbs_bist_ctrl_if;
    logic       tx_valid;
    logic [3:0] tx_data;
    logic       rx_valid;
    logic [3:0] rx_data;

    modport master (
        output tx_valid,
        output tx_data,
        input  rx_valid,
        input  rx_data
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        output rx_valid,
        output rx_data
    );
endinterface

// File: rtl/prbs_bist_ctrl.sv
// PRBS BIST controller: streams a seeded 4-bit PRBS burst and checks
// the looped-back words against an identically seeded reference.
module prbs_bist_ctrl #(
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       seed,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic [7:0]       err_cnt,
    output logic             timeout,
    output logic             pass,
    prbs_bist_ctrl_if.master lb
);
    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEED,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state;
    logic [3:0]       seed_q;
    logic [3:0]       gen_q;
    logic [3:0]       ref_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] tx_cnt;
    logic [LEN_W-1:0] rx_cnt;
    logic [LEN_W-1:0] rx_nxt;
    logic [TO_W-1:0]  to_cnt;
    logic             tx_vld_q;
    logic             chk;
    logic             mis;
    logic [7:0]       err_nxt;

    function automatic logic [3:0] lfsr_step(input logic [3:0] s);
        return {s[2:0], s[0] ^ s[3]};
    endfunction

    assign lb.tx_valid = tx_vld_q;
    assign lb.tx_data  = gen_q;

    // Checker view including the word arriving this cycle, so DRAIN can
    // finish on the final compare without an extra cycle.
    always_comb begin
        chk     = (state == S_RUN || state == S_DRAIN)
                  && lb.rx_valid && (rx_cnt < len_q);
        mis     = chk && (lb.rx_data != ref_q);
        err_nxt = (mis && err_cnt != 8'hFF) ? err_cnt + 8'd1 : err_cnt;
        rx_nxt  = chk ? rx_cnt + LEN_ONE : rx_cnt;
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state    <= S_IDLE;
            seed_q   <= 4'h0;
            gen_q    <= 4'h0;
            ref_q    <= 4'h0;
            len_q    <= '0;
            tx_cnt   <= '0;
            rx_cnt   <= '0;
            to_cnt   <= '0;
            tx_vld_q <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err_cnt  <= 8'd0;
            timeout  <= 1'b0;
            pass     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        seed_q  <= (seed == 4'h0) ? 4'h1 : seed;
                        len_q   <= len;
                        err_cnt <= 8'd0;
                        timeout <= 1'b0;
                        pass    <= 1'b0;
                        busy    <= 1'b1;
                        state   <= S_SEED;
                    end
                end
                S_SEED: begin
                    gen_q  <= seed_q;
                    ref_q  <= seed_q;
                    tx_cnt <= '0;
                    rx_cnt <= '0;
                    to_cnt <= '0;
                    if (len_q == '0) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_cnt == 8'd0) && !timeout;
                        state <= S_DONE;
                    end else begin
                        tx_vld_q <= 1'b1;
                        state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    gen_q   <= lfsr_step(gen_q);
                    tx_cnt  <= tx_cnt + LEN_ONE;
                    err_cnt <= err_nxt;
                    rx_cnt  <= rx_nxt;
                    if (chk) ref_q <= lfsr_step(ref_q);
                    if (tx_cnt + LEN_ONE == len_q) begin
                        tx_vld_q <= 1'b0;
                        state    <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    to_cnt  <= to_cnt + TO_W'(1);
                    err_cnt <= err_nxt;
                    rx_cnt  <= rx_nxt;
                    if (chk) ref_q <= lfsr_step(ref_q);
                    if (rx_nxt == len_q) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_nxt == 8'd0);
                        state <= S_DONE;
                    end else if (to_cnt == TO_LAST) begin
                        timeout <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= 1'b0;
                        state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_prbs_bist_ctrl.sv
// Randomized bench for prbs_bist_ctrl: loopback with latency, drops and
// bit flips, checked against a table-driven PRBS and outcome model.
module tb_prbs_bist_ctrl;
    localparam int LEN_W = 8;
    localparam int TO    = 64;

    logic             clock = 1'b0;
    logic             rst;
    logic             start;
    logic [3:0]       seed;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             done;
    logic [7:0]       err_cnt;
    logic             timeout;
    logic             pass;

    always #5 clock = ~clock;

    prbs_bist_ctrl_if lb ();

    prbs_bist_ctrl #(
        .LEN_W   (LEN_W),
        .TIMEOUT (TO)
    ) dut (
        .clock   (clock),
        .rst     (rst),
        .start   (start),
        .seed    (seed),
        .len     (len),
        .busy    (busy),
        .done    (done),
        .err_cnt (err_cnt),
        .timeout (timeout),
        .pass    (pass),
        .lb      (lb)
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic [3:0] seq [15] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hD, 4'hA,
                             4'h5, 4'hB, 4'h6, 4'hC, 4'h9, 4'h2, 4'h4,
                             4'h8};
    logic [3:0] flip [256];
    bit         zero_rx;
    logic       hist_v [600];
    logic [3:0] hist_d [600];
    int         hist_i [600];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Word k of the burst: walk the published period-15 sequence.
    function automatic logic [3:0] exp_word(input logic [3:0] sd,
                                            input int k);
        logic [3:0] s;
        int idx;
        s   = (sd == 4'h0) ? 4'h1 : sd;
        idx = 0;
        for (int i = 0; i < 15; i++) if (seq[i] == s) idx = i;
        return seq[(idx + k) % 15];
    endfunction

    task automatic run_test(input logic [3:0] sd, input int ln,
                            input int lat, input int nret);
        int ret, e_err, e_done, done_t, ndone, nbusy, tx_seen, src;
        bit e_to, e_pass;
        ret   = (nret < ln) ? nret : ln;
        e_err = 0;
        for (int i = 0; i < ret; i++)
            if (zero_rx || flip[i] != 4'h0) e_err++;
        if (e_err > 255) e_err = 255;
        e_to   = (ret < ln);
        e_pass = (e_err == 0) && !e_to;
        if (ln == 0) e_done = 1;
        else if (e_to) e_done = ln + 1 + TO;
        else e_done = ((lat > 1) ? ln + lat : ln + 1) + 1;

        @(negedge clock);
        start       = 1'b1;
        seed        = sd;
        len         = LEN_W'(ln);
        lb.rx_valid = 1'b1;
        lb.rx_data  = 4'($urandom);
        @(negedge clock);
        start      = 1'b0;
        lb.rx_data = 4'($urandom);
        done_t  = -1;
        ndone   = 0;
        nbusy   = 0;
        tx_seen = 0;
        for (int t = 0; t < ln + lat + TO + 8; t++) begin
            if (busy) nbusy++;
            if (done) begin
                ndone++;
                if (done_t < 0) begin
                    done_t = t;
                    check("err_cnt", err_cnt, e_err);
                    check("timeout", timeout, e_to);
                    check("pass", pass, e_pass);
                end
            end
            hist_v[t] = lb.tx_valid;
            hist_d[t] = lb.tx_data;
            hist_i[t] = tx_seen;
            if (lb.tx_valid) begin
                check("tx_data", lb.tx_data, exp_word(sd, tx_seen));
                tx_seen++;
            end
            if (t == 2 && ln >= 3) begin
                start = 1'b1;
                seed  = 4'($urandom);
                len   = LEN_W'($urandom);
            end
            if (t == 3) start = 1'b0;
            if (t > 0) begin
                src = t - lat;
                if (src >= 0 && hist_v[src] && hist_i[src] < nret) begin
                    lb.rx_valid = 1'b1;
                    lb.rx_data  = zero_rx ? 4'h0
                                : hist_d[src] ^ flip[hist_i[src]];
                end else begin
                    lb.rx_valid = 1'b0;
                end
            end
            if (done_t >= 0 && t >= done_t + 1) begin
                check("pass_hold", pass, e_pass);
                break;
            end
            @(negedge clock);
        end
        lb.rx_valid = 1'b0;
        start       = 1'b0;
        check("done_cycle", done_t, e_done);
        check("done_pulses", ndone, 1);
        check("busy_cycles", nbusy, e_done);
        check("tx_words", tx_seen, ln);
    endtask

    task automatic reset_mid_run();
        int nd;
        nd = 0;
        @(negedge clock);
        start = 1'b1;
        seed  = 4'h5;
        len   = LEN_W'(20);
        @(negedge clock);
        start       = 1'b0;
        lb.rx_valid = 1'b1;
        lb.rx_data  = 4'h0;
        repeat (5) @(negedge clock);
        check("mid_busy", busy, 1'b1);
        check("mid_err_nz", err_cnt != 8'd0, 1'b1);
        rst = 1'b1;
        @(negedge clock);
        lb.rx_valid = 1'b0;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_tx_valid", lb.tx_valid, 1'b0);
        check("rst_tx_data", lb.tx_data, 4'h0);
        check("rst_err", err_cnt, 8'd0);
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (done || busy) nd++;
        end
        check("post_rst_quiet", nd, 0);
    endtask

    initial begin
        int ln, lat, nret;
        rst         = 1'b1;
        start       = 1'b0;
        seed        = 4'h0;
        len         = '0;
        lb.rx_valid = 1'b0;
        lb.rx_data  = 4'h0;
        zero_rx     = 1'b0;
        foreach (flip[i]) flip[i] = 4'h0;
        repeat (3) @(negedge clock);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_tx_valid", lb.tx_valid, 1'b0);
        check("reset_tx_data", lb.tx_data, 4'h0);
        check("reset_err", err_cnt, 8'd0);
        check("reset_timeout", timeout, 1'b0);
        check("reset_pass", pass, 1'b0);
        rst = 1'b0;

        run_test(4'h1, 15, 3, 15);
        run_test(4'h0, 4, 0, 4);
        flip[2] = 4'h1;
        flip[5] = 4'h1;
        run_test(4'hA, 8, 1, 8);
        foreach (flip[i]) flip[i] = 4'h0;
        run_test(4'h1, 5, 2, 3);
        run_test(4'h3, 0, 1, 0);
        zero_rx = 1'b1;
        run_test(4'h6, 255, 1, 255);
        zero_rx = 1'b0;
        reset_mid_run();

        repeat (20) begin
            ln   = int'($urandom_range(0, 40));
            lat  = int'($urandom_range(0, 5));
            nret = ($urandom_range(0, 3) == 0)
                   ? int'($urandom_range(0, ln)) : ln;
            foreach (flip[i])
                flip[i] = ($urandom_range(0, 5) == 0)
                          ? 4'($urandom_range(1, 15)) : 4'h0;
            run_test(4'($urandom), ln, lat, nret);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
